inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Multi-channel instruction buffer between inst_fetch and inst_decode.
- Accepts up to N_FETCH fetched instructions per cycle and presents up to N_ISSUE oldest instructions per cycle to decode.
- Decouples icache stalls from decode back-pressure as the core moves beyond single issue.
- Flushed on exception or branch redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2*max(N_FETCH,N_ISSUE).
- N_FETCH, 2, instructions pushed per cycle (1..4).
- N_ISSUE, 2, instructions presented per cycle (1..4).
- ADDR_WIDTH, 32, width of pc and instruction word fields.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all contents (except_req.valid or resolved mispredict)
- push_valid  input  N_FETCH  per-channel push request; must be contiguous from bit 0
- push_pc  input  N_FETCH*ADDR_WIDTH  pc per channel; channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- push_inst  input  N_FETCH*32  instruction word per channel
- push_fault  input  N_FETCH  mmu/fetch fault flag per channel
- push_ready  output  1  free slots >= N_FETCH
- pop_valid  output  N_ISSUE  thermometer; bit i set when entry i (oldest first) exists
- pop_pc  output  N_ISSUE*ADDR_WIDTH  pc of oldest entries
- pop_inst  output  N_ISSUE*32  instruction of oldest entries
- pop_fault  output  N_ISSUE  fault flag of oldest entries
- pop_count  input  $clog2(N_ISSUE+1)  entries consumed by decode this cycle
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular array of DEPTH entries {pc, inst, fault}. Read pointer rd_ptr and write pointer wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0. Outputs during reset: pop_valid=0, push_ready=1, count=0. Entry contents are don't-care. Reset mid-operation drops everything immediately.
- push_ready is combinational: (DEPTH - count) >= N_FETCH. It depends only on registered count, not on this cycle's pop.
- Push: n_push = number of leading ones in push_valid; bits above the first zero are ignored. When push_ready=1 and flush=0:
  - channel i is written to entry (wr_ptr+i) mod DEPTH for i < n_push;
  - wr_ptr += n_push next cycle.
- When push_ready=0, the push is dropped whole (no partial accept); fetch holds its data.
- Pop outputs: combinational from the array. Slot i shows entry (rd_ptr+i) mod DEPTH; pop_valid[i] = (i < count).
- Pop: n_pop = min(pop_count, count); larger values are clamped. rd_ptr += n_pop next cycle.
- Occupancy: count_next = count + n_push_accepted - n_pop. Simultaneous push and pop are both honoured in the same cycle.
- Flush (synchronous): next cycle rd_ptr=wr_ptr=0 and count=0. Any same-cycle push and pop are discarded. Flush has priority over push and pop.
- Latency: a pushed entry appears on pop outputs the cycle after the push (without bypass).
- Wrap-around: writes and reads that straddle DEPTH-1 → 0 are contiguous modulo DEPTH.
- Full: count == DEPTH gives push_ready=0 (it goes to 0 earlier, once free slots < N_FETCH).
- Empty: count=0 gives pop_valid=0 and pop_count is ignored.
- Invariant: count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- With the macro, when count=0 and flush=0, pop outputs mirror the push channels combinationally in the same cycle:
  - pop_valid[i] = push_valid[i] for i < min(N_FETCH, N_ISSUE);
  - the first n_pop pushed entries are consumed without being written;
  - the remaining n_push-n_pop entries are written starting at wr_ptr.
  - count_next = n_push - n_pop.
- Without the macro: minimum push-to-pop latency is 1 cycle, and pop_valid=0 whenever count=0.

Test Plan:
- Reset mid-fill: push 2 entries, assert rst asynchronously between edges → count=0, pop_valid=00 and push_ready=1 immediately, without waiting for a clock edge.
- Fill to full (DEPTH=8, N_FETCH=2), push 4 cycles, pop_count=0 → count=8, push_ready=0 after count=6. A 5th push is dropped; contents are unchanged on readback.
- Wrap-around with ordering preserved:
  - push pcs 0x100..0x11C in pairs, pop 2 per cycle, 10 cycles;
  - pop_pc stays in strict ascending order across the 7→0 pointer wrap.
- Simultaneous push/pop with clamp:
  - count=1, push 2, pop_count=2 → n_pop=1, count_next=2;
  - pop_pc[0] holds the first pushed pc.
- Flush with simultaneous push: count=5, flush=1 with push_valid=11 → next cycle count=0, pop_valid=00, pushed entries absent.
- Non-contiguous push and bypass:
  - push_valid=10 → nothing written, count unchanged;
  - with INST_QUEUE_BYPASS_EN, empty queue, push_valid=11, pop_count=1 → same-cycle pop_valid=11, count_next=1 holding channel 1.

Source files
------------

// File: rtl/inst_queue.sv
// Multi-channel instruction buffer between fetch and decode: N_FETCH pushes, N_ISSUE pops per cycle.
// Optional same-cycle push-to-pop bypass on an empty queue is enabled by INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned N_FETCH    = 2,
  parameter int unsigned N_ISSUE    = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [N_FETCH-1:0]              push_valid,
  input  logic [N_FETCH*ADDR_WIDTH-1:0]   push_pc,
  input  logic [N_FETCH*32-1:0]           push_inst,
  input  logic [N_FETCH-1:0]              push_fault,
  output logic                            push_ready,
  output logic [N_ISSUE-1:0]              pop_valid,
  output logic [N_ISSUE*ADDR_WIDTH-1:0]   pop_pc,
  output logic [N_ISSUE*32-1:0]           pop_inst,
  output logic [N_ISSUE-1:0]              pop_fault,
  input  logic [$clog2(N_ISSUE+1)-1:0]    pop_count,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned NByp = (N_FETCH < N_ISSUE) ? N_FETCH : N_ISSUE;

  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic [31:0]           inst_q  [DEPTH];
  logic                  fault_q [DEPTH];

  logic [CntW-1:0] n_push, n_pop, n_wr, skip, byp_cnt, pop_req;
  logic            push_en, byp_en, run;

  assign pop_req    = CntW'(pop_count);
  assign push_ready = (CntW'(DEPTH) - count_q) >= CntW'(N_FETCH);
  assign push_en    = push_ready && !flush;
  assign count      = count_q;

`ifdef INST_QUEUE_BYPASS_EN
  // Bypass only when nothing older is queued, so ordering is preserved.
  assign byp_en = (count_q == '0) && !flush && !rst;
`else
  assign byp_en = 1'b0;
`endif

  // Only the leading run of valid channels counts; bits after the first gap are ignored.
  always_comb begin
    n_push = '0;
    run    = 1'b1;
    for (int i = 0; i < N_FETCH; i++) begin
      if (run && push_valid[i]) begin
        n_push = n_push + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    skip    = '0;
    n_pop   = '0;
    byp_cnt = '0;
    if (byp_en) begin
      byp_cnt = (n_push < CntW'(NByp)) ? n_push : CntW'(NByp);
      skip    = (pop_req < byp_cnt) ? pop_req : byp_cnt;
    end else begin
      n_pop = (pop_req < count_q) ? pop_req : count_q;
    end
    n_wr = push_en ? (n_push - skip) : '0;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + n_pop[PtrW-1:0];
      wr_ptr_d = wr_ptr_q + n_wr[PtrW-1:0];
      count_d  = count_q + n_wr - n_pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries consumed by bypass (the first `skip` channels) are never written.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < N_FETCH; i++) begin
        if ((CntW'(i) >= skip) && (CntW'(i) < n_push)) begin
          pc_q[wr_ptr_q + PtrW'(CntW'(i) - skip)]    <= push_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
          inst_q[wr_ptr_q + PtrW'(CntW'(i) - skip)]  <= push_inst[i*32 +: 32];
          fault_q[wr_ptr_q + PtrW'(CntW'(i) - skip)] <= push_fault[i];
        end
      end
    end
  end

  always_comb begin
    pop_valid = '0;
    pop_pc    = '0;
    pop_inst  = '0;
    pop_fault = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      if (byp_en) begin
        if (i < int'(NByp)) begin
          pop_valid[i]                       = CntW'(i) < n_push;
          pop_pc[i*ADDR_WIDTH +: ADDR_WIDTH] = push_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
          pop_inst[i*32 +: 32]               = push_inst[i*32 +: 32];
          pop_fault[i]                       = push_fault[i];
        end
      end else begin
        pop_valid[i]                       = CntW'(i) < count_q;
        pop_pc[i*ADDR_WIDTH +: ADDR_WIDTH] = pc_q[rd_ptr_q + PtrW'(i)];
        pop_inst[i*32 +: 32]               = inst_q[rd_ptr_q + PtrW'(i)];
        pop_fault[i]                       = fault_q[rd_ptr_q + PtrW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8, N_FETCH=2, N_ISSUE=2) with a pc scoreboard queue.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, push_ready;
  logic [1:0]  push_valid, push_fault, pop_valid, pop_fault, pop_count;
  logic [63:0] push_pc, push_inst, pop_pc, pop_inst;
  logic [3:0]  count;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] sb[$];

  inst_queue dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_inst  (push_inst),
    .push_fault (push_fault),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_pc     (pop_pc),
    .pop_inst   (pop_inst),
    .pop_fault  (pop_fault),
    .pop_count  (pop_count),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive, check outputs mid-cycle, update model, advance one clock.
  task automatic step(input logic [1:0] pv, input logic [31:0] pc0, input logic [1:0] pcnt,
                      input logic fl);
    logic [31:0] in_pc [2];
    logic [31:0] view  [$];
    int sz, np, nv, npop;
    bit rdy, byp;
    in_pc[0]   = pc0;
    in_pc[1]   = pc0 + 32'd4;
    push_valid = pv;
    push_pc    = {in_pc[1], in_pc[0]};
    push_inst  = {inst_of(in_pc[1]), inst_of(in_pc[0])};
    push_fault = {in_pc[1][3], in_pc[0][3]};
    pop_count  = pcnt;
    flush      = fl;
    #3;
    sz  = sb.size();
    np  = pv[0] ? (pv[1] ? 2 : 1) : 0;
    rdy = (8 - sz) >= 2;
    byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    if (byp) begin
      nv = np;
      for (int i = 0; i < np; i++) view.push_back(in_pc[i]);
    end else begin
      nv = (sz < 2) ? sz : 2;
      for (int i = 0; i < nv; i++) view.push_back(sb[i]);
    end
    chk("count", 32'(count), 32'(sz));
    chk("push_ready", 32'(push_ready), 32'(rdy));
    chk("pop_valid", 32'(pop_valid), (nv == 2) ? 32'd3 : ((nv == 1) ? 32'd1 : 32'd0));
    for (int i = 0; i < nv; i++) begin
      chk($sformatf("pop_pc[%0d]", i), pop_pc[i*32 +: 32], view[i]);
      chk($sformatf("pop_inst[%0d]", i), pop_inst[i*32 +: 32], inst_of(view[i]));
      chk($sformatf("pop_fault[%0d]", i), 32'(pop_fault[i]), 32'(view[i][3]));
    end
    if (fl) begin
      sb.delete();
    end else if (byp) begin
      npop = (int'(pcnt) < np) ? int'(pcnt) : np;
      for (int i = npop; i < np; i++) sb.push_back(in_pc[i]);
    end else begin
      npop = (int'(pcnt) < sz) ? int'(pcnt) : sz;
      repeat (npop) void'(sb.pop_front());
      if (rdy) for (int i = 0; i < np; i++) sb.push_back(in_pc[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = '0;
    push_pc    = '0;
    push_inst  = '0;
    push_fault = '0;
    pop_count  = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-fill, asserted between edges.
    step(2'b11, 32'h10, 2'd0, 1'b0);
    step(2'b00, 32'h0, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
    chk("midrst_push_ready", 32'(push_ready), 32'd1);
    sb.delete();
    #1;
    rst = 1'b0;

    // Fill to full, dropped 5th push, readback.
    for (int k = 0; k < 4; k++) step(2'b11, 32'h200 + 32'(8 * k), 2'd0, 1'b0);
    step(2'b11, 32'h2F0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) step(2'b00, 32'h0, 2'd2, 1'b0);

    // Offset pointers by one so the pair stream straddles the 7->0 wrap.
    step(2'b01, 32'hF0, 2'd0, 1'b0);
    step(2'b00, 32'h0, 2'd1, 1'b0);
    for (int k = 0; k < 10; k++)
      step((k < 4) ? 2'b11 : 2'b00, 32'h100 + 32'(8 * k), 2'd2, 1'b0);

    // Simultaneous push/pop with pop_count clamped to occupancy.
    step(2'b01, 32'h300, 2'd0, 1'b0);
    step(2'b11, 32'h304, 2'd2, 1'b0);
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // Flush at count=5 with a same-cycle push.
    step(2'b11, 32'h310, 2'd0, 1'b0);
    step(2'b01, 32'h320, 2'd0, 1'b0);
    step(2'b11, 32'h330, 2'd0, 1'b1);
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // Non-contiguous push is ignored; oversized pop_count clamps.
    step(2'b01, 32'h400, 2'd0, 1'b0);
    step(2'b10, 32'h410, 2'd0, 1'b0);
    step(2'b00, 32'h0, 2'd3, 1'b0);
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // Push into empty queue while popping one (bypass path when enabled).
    step(2'b11, 32'h500, 2'd1, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
